// File: rtl/module_piso_serializer_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
// Defining PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

    typedef enum logic {IDLE, SHIFT} piso_state_t;

`ifdef PISO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Bits per frame is ancho + parity; the counter runs from frame length - 1 down to 0
    function automatic int piso_cnt_width(input int ancho, input int parity);
        return $clog2(ancho + parity);
    endfunction

endpackage

// File: rtl/module_piso_serializer_if.sv
// Load handshake and serial output bundle of the PISO serializer.
// master = word source / serial sink, slave = serializer.
interface module_piso_serializer_if #(parameter int ANCHO = 8);

    logic [ANCHO-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             serial_last;
    logic             done;

    modport master (
        output data_in, load_valid, shift_en,
        input  load_ready, serial_out, serial_valid, serial_last, done
    );

    modport slave (
        input  data_in, load_valid, shift_en,
        output load_ready, serial_out, serial_valid, serial_last, done
    );

endinterface

// File: rtl/module_piso_serializer_bit_counter.sv
// Loadable down-counter with zero flag; load wins over dec, dec stops at zero.
// Single-cycle update, no backpressure.
module module_piso_bit_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/module_piso_serializer.sv
// Parallel-in serial-out transmitter; first bit valid the cycle after the load handshake.
// Busy (load_ready=0) for the whole frame; shift_en paces bits. PISO_PARITY_EN adds an even-parity bit.
module module_piso_serializer
    import piso_pkg::*;
#(
    parameter int ANCHO     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    module_piso_serializer_if.slave  bus
);

    localparam int NBITS = ANCHO + PARITY_BITS;
    localparam int CW    = piso_cnt_width(ANCHO, PARITY_BITS);

    piso_state_t      state, state_nxt;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] load_word;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             load_fire, shift_fire, last_fire;
    logic             done_q;

    // Parity rides in the shift register behind the data so it leaves after the last data bit
`ifdef PISO_PARITY_EN
    assign load_word = MSB_FIRST ? {bus.data_in, ^bus.data_in} : {^bus.data_in, bus.data_in};
`else
    assign load_word = bus.data_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_fire  = 1'b0;
        shift_fire = 1'b0;
        last_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load_valid) begin
                    load_fire = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.shift_en) begin
                    if (cnt_zero) begin
                        last_fire = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        shift_fire = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_fire;
            if (load_fire) begin
                shreg <= load_word;
            end else if (shift_fire) begin
                shreg <= MSB_FIRST ? {shreg[NBITS-2:0], 1'b0} : {1'b0, shreg[NBITS-1:1]};
            end
        end
    end

    module_piso_bit_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load_fire),
        .load_val (CW'(NBITS - 1)),
        .dec      (shift_fire),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    assign bus.load_ready   = (state == IDLE);
    assign bus.serial_valid = (state == SHIFT);
    assign bus.serial_out   = (state == SHIFT) && (MSB_FIRST ? shreg[NBITS-1] : shreg[0]);
    assign bus.serial_last  = (state == SHIFT) && cnt_zero;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_module_piso_serializer.sv
// Scoreboarded bench for the PISO serializer: LSB-first and MSB-first instances,
// expected bit streams queued at load time and checked by per-instance monitors.
module tb_module_piso_serializer;

    localparam int ANCHO = 8;
`ifdef PISO_PARITY_EN
    localparam int NB = ANCHO + 1;
`else
    localparam int NB = ANCHO;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    module_piso_serializer_if #(.ANCHO(ANCHO)) if0 (), if1 ();

    module_piso_serializer #(.ANCHO(ANCHO), .MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    module_piso_serializer #(.ANCHO(ANCHO), .MSB_FIRST(1'b1)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [1:0] q0[$];   // {bit, last}
    logic [1:0] q1[$];
    logic dexp0 = 1'b0;
    logic dexp1 = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bad(input string msg);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", msg, $time);
    endtask

    // seq[i] is the i-th bit expected on the wire; par is the hand-computed parity bit
    task automatic push(input bit sel, input logic [7:0] seq, input logic par);
        for (int i = 0; i < ANCHO; i++) begin
            logic l;
            l = (i == ANCHO - 1) && (NB == ANCHO);
            if (sel) q1.push_back({seq[i], l});
            else     q0.push_back({seq[i], l});
        end
        if (NB > ANCHO) begin
            if (sel) q1.push_back({par, 1'b1});
            else     q0.push_back({par, 1'b1});
        end
    endtask

    task automatic do_load(input bit sel, input logic [7:0] d, output int n);
        logic rdy;
        rdy = 1'b0;
        n = 0;
        if (sel) begin if1.data_in = d; if1.load_valid = 1'b1; end
        else     begin if0.data_in = d; if0.load_valid = 1'b1; end
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = sel ? if1.load_ready : if0.load_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) bad("load_timeout: load_ready stayed 0, required 1");
    endtask

    task automatic wait_idle(input bit sel);
        logic rdy;
        int n;
        rdy = 1'b0;
        n = 0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = sel ? if1.load_ready : if0.load_ready;
            n++;
        end
        if (!rdy) bad("idle_timeout: load_ready stayed 0, required 1");
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            dexp0 = 1'b0;
        end else begin
            chk("done_lsb", if0.done, dexp0);
            dexp0 = 1'b0;
            if (!if0.serial_valid) begin
                chk("idle_out_lsb", if0.serial_out, 1'b0);
                chk("idle_last_lsb", if0.serial_last, 1'b0);
            end else if (q0.size() == 0) begin
                bad("extra_bit_lsb: serial_valid=1, required 0");
            end else begin
                chk("bit_lsb", if0.serial_out, q0[0][1]);
                chk("last_lsb", if0.serial_last, q0[0][0]);
                if (if0.shift_en) begin
                    dexp0 = q0[0][0];
                    void'(q0.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            dexp1 = 1'b0;
        end else begin
            chk("done_msb", if1.done, dexp1);
            dexp1 = 1'b0;
            if (!if1.serial_valid) begin
                chk("idle_out_msb", if1.serial_out, 1'b0);
                chk("idle_last_msb", if1.serial_last, 1'b0);
            end else if (q1.size() == 0) begin
                bad("extra_bit_msb: serial_valid=1, required 0");
            end else begin
                chk("bit_msb", if1.serial_out, q1[0][1]);
                chk("last_msb", if1.serial_last, q1[0][0]);
                if (if1.shift_en) begin
                    dexp1 = q1[0][0];
                    void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: summary not reached");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        if0.data_in = '0; if0.load_valid = 1'b0; if0.shift_en = 1'b0;
        if1.data_in = '0; if1.load_valid = 1'b0; if1.shift_en = 1'b0;

        #1;
        chk("rst_ready", if0.load_ready, 1'b1);
        chk("rst_valid", if0.serial_valid, 1'b0);
        chk("rst_out", if0.serial_out, 1'b0);
        chk("rst_last", if0.serial_last, 1'b0);
        chk("rst_done", if0.done, 1'b0);
        chk("rst_ready_msb", if1.load_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // LSB first, shift_en tied high: A5 -> 1,0,1,0,0,1,0,1
        if0.shift_en = 1'b1;
        push(1'b0, 8'hA5, 1'b0);
        do_load(1'b0, 8'hA5, n);
        if0.load_valid = 1'b0;
        wait_idle(1'b0);

        // MSB first: 3C -> 0,0,1,1,1,1,0,0
        if1.shift_en = 1'b1;
        push(1'b1, 8'h3C, 1'b0);
        do_load(1'b1, 8'h3C, n);
        if1.load_valid = 1'b0;
        wait_idle(1'b1);

        // shift_en every 4th cycle; mid-frame load of 00 must be ignored
        if0.shift_en = 1'b0;
        push(1'b0, 8'h81, 1'b0);
        do_load(1'b0, 8'h81, n);
        if0.load_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4 * NB + 6; i++) begin
            if0.shift_en = (i % 4 == 3);
            if (i == 10) begin if0.data_in = 8'h00; if0.load_valid = 1'b1; end
            if (i == 11) if0.load_valid = 1'b0;
            @(negedge clk);
            if (i == 10) chk("ready_busy", if0.load_ready, 1'b0);
            if (if0.serial_valid) cnt++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (cnt != 4 * NB) begin
            miscompares++;
            $display("FAIL frame_len: got %0d cycles expected %0d", cnt, 4 * NB);
        end
        wait_idle(1'b0);

        // back-to-back: 01 then 80 with load_valid held; second accepted in done cycle
        if0.shift_en = 1'b1;
        push(1'b0, 8'h01, 1'b1);
        push(1'b0, 8'h80, 1'b1);
        do_load(1'b0, 8'h01, n);
        do_load(1'b0, 8'h80, n);
        if0.load_valid = 1'b0;
        vectors++;
        if (n != NB + 1) begin
            miscompares++;
            $display("FAIL b2b_accept: accepted after %0d cycles expected %0d", n, NB + 1);
        end
        wait_idle(1'b0);

        // asynchronous reset after 3 shifted bits, with a load offered during reset
        push(1'b0, 8'hFF, 1'b0);
        do_load(1'b0, 8'hFF, n);
        if0.load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        if0.data_in = 8'hAA;
        if0.load_valid = 1'b1;
        #1;
        chk("arst_valid", if0.serial_valid, 1'b0);
        chk("arst_ready", if0.load_ready, 1'b1);
        chk("arst_out", if0.serial_out, 1'b0);
        chk("arst_done", if0.done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        if0.load_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", if0.load_ready, 1'b1);
        chk("post_rst_valid", if0.serial_valid, 1'b0);
        repeat (4) @(posedge clk);
        #1;

`ifdef PISO_PARITY_EN
        // 07: parity 1; 03: parity 0
        push(1'b0, 8'h07, 1'b1);
        do_load(1'b0, 8'h07, n);
        if0.load_valid = 1'b0;
        wait_idle(1'b0);
        push(1'b0, 8'h03, 1'b0);
        do_load(1'b0, 8'h03, n);
        if0.load_valid = 1'b0;
        wait_idle(1'b0);
`endif

        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d bits never sent, expected 0", q0.size(), q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/module_piso_serializer.md
Name: module_piso_serializer

Overview:
Parallel-in, serial-out transmitter. It accepts an ANCHO-bit word through a valid/ready load handshake and shifts it out one bit per shift_en strobe. It is the serial-side counterpart of the team's parallel storage registers and feeds bit-serial links such as UART-style, SPI-style or LED-chain outputs. An external tick generator paces the shifting through shift_en.

Parameters:
ANCHO, 8, word width in bits; legal range 2 to 32.
MSB_FIRST, 0, 0 = LSB shifted out first; 1 = MSB shifted out first.

Ports:
clk  input  1  system clock; all state updates on posedge clk.
rst  input  1  reset, asynchronous and active-high; forces IDLE.
data_in  input  ANCHO  parallel word to transmit.
load_valid  input  1  data_in is valid this cycle.
load_ready  output  1  serializer can accept a word (high only in IDLE).
shift_en  input  1  bit-rate strobe: advance to the next bit when high.
serial_out  output  1  current serial bit.
serial_valid  output  1  serial_out carries a word bit (high only in SHIFT).
serial_last  output  1  current bit is the final bit of the frame.
done  output  1  one-cycle pulse after the final bit is consumed.

Behaviour:
- Reset values: state=IDLE, shift register=0, bit counter=0, load_ready=1, serial_out=0, serial_valid=0, serial_last=0, done=0.
- Reset is asynchronous. Asserting rst mid-frame aborts the frame immediately; the word is discarded and no done pulse is produced.
- States: IDLE and SHIFT.
- IDLE:
  - load_ready=1.
  - On load_valid & load_ready at a clock edge: capture data_in into the shift register, set counter=NBITS-1, go to SHIFT.
  - shift_en is ignored in IDLE.
- NBITS = ANCHO, or ANCHO+1 with the optional feature. Counter width is $clog2(NBITS).
- SHIFT:
  - load_ready=0; load_valid is ignored and data_in is not sampled.
  - serial_valid=1.
  - serial_out = shreg[0] when MSB_FIRST=0, else shreg[ANCHO-1].
  - serial_last=1 while counter==0.
- Latency: the first bit appears on serial_out in the cycle after the load handshake.
- Shifting in SHIFT:
  - shift_en=1 and counter!=0: shift the register one position toward the output end (zero fill), decrement counter.
  - shift_en=1 and counter==0: go to IDLE and pulse done=1 for exactly the next cycle.
  - shift_en=0: hold the shift register, counter and outputs.
- Throughput: a new load is accepted no earlier than the cycle done is high, which is the first IDLE cycle. Minimum frame period is NBITS+1 cycles when shift_en is held high.
- serial_out outside SHIFT is 0.
- Simultaneous rst and load_valid: reset wins; nothing is captured.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - At load, also register parity_bit = ^data_in (even parity).
  - After the ANCHO data bits, one extra bit equal to parity_bit is sent.
  - NBITS = ANCHO+1; serial_last marks the parity bit.
- Undefined: no parity logic; NBITS = ANCHO; serial_last marks the final data bit.

Decomposition:
- Package piso_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_t;
  - a function returning the counter width from ANCHO and the parity option.
- One natural sub-module: module_piso_bit_counter.
  - Loadable down-counter with load, dec and a zero flag.
  - Reset to 0 on rst.

Test Plan:
- Reset mid-frame: load 8'hFF, assert rst after 3 shifted bits -> serial_valid=0, load_ready=1 and serial_out=0 immediately (asynchronous); no done pulse.
- LSB-first, shift_en tied high, ANCHO=8, load 8'hA5 -> serial_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles; serial_last only on the 8th bit; done high in the following cycle.
- MSB_FIRST=1, load 8'h3C -> sequence 0,0,1,1,1,1,0,0.
- shift_en strobed every 4th cycle, load 8'h81 -> each bit held for 4 cycles; the frame lasts 32 cycles; load_valid pulsed mid-frame with 8'h00 is ignored and the output is unchanged.
- Back-to-back: load_valid held high with 8'h01 then 8'h80 -> the second word is accepted in the done cycle; bit stream is 1,0,0,0,0,0,0,0, then 0,0,0,0,0,0,0,1.
- PISO_PARITY_EN defined:
  - Load 8'h07 -> 9 bits; ninth bit 1; serial_last on the ninth bit.
  - Load 8'h03 -> ninth bit 0.
